// File: rtl/onehot_3to8_strobe_decoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_3to8_strobe_decoder
// Purpose  : Sequenced 3-to-8 one-hot decoder. Accepts {index, hold length}
//            over valid/ready, drives one output line for in_len+1 cycles,
//            then forces an all-zero gap of GAP_CYCLES cycles so consecutive
//            selections are break-before-make.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_3to8_strobe_decoder #(
  parameter int GAP_CYCLES = 1,   // all-zero cycles after each strobe, 1..15
  parameter int LEN_W      = 4    // width of the hold-length field
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_idx,
  input  logic [LEN_W-1:0] in_len,
  output logic [7:0]       O,
  output logic             busy,
  output logic             done
);

  // --------------------------------------------------------------------------
  // State encoding and constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_active = 2'd1;
  localparam logic [1:0] c_st_gap    = 2'd2;

  localparam int         c_gap_w     = 4;
  // Gap counter counts down to zero, so it is loaded with one less than the
  // number of gap cycles wanted.
  localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(GAP_CYCLES - 1);
  localparam logic [c_gap_w-1:0] c_gap_one  = c_gap_w'(1);
  localparam logic [LEN_W-1:0]   c_len_one  = {{(LEN_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Flops (_q) and their next values (_d)
  // --------------------------------------------------------------------------
  logic [1:0]         state_q,    state_d;
  logic [2:0]         idx_q,      idx_d;
  logic [LEN_W-1:0]   len_cnt_q,  len_cnt_d;
  logic [c_gap_w-1:0] gap_cnt_q,  gap_cnt_d;
  logic [7:0]         o_q,        o_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic               in_ready_q, in_ready_d;

  // State register plus registered outputs; reset aborts any strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= c_st_idle;
      idx_q      <= 3'd0;
      len_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      o_q        <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_cnt_q  <= len_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      o_q        <= o_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state logic: capture on accept, count down the hold, then the gap.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_cnt_d = len_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      c_st_idle: begin
        // Inputs are sampled only here; while busy they are ignored and a
        // pending in_valid simply waits for the return to IDLE.
        if (in_valid) begin
          state_d   = c_st_active;
          idx_d     = in_idx;
          len_cnt_d = in_len;
        end
      end
      c_st_active: begin
        // Counting down from in_len to zero gives in_len+1 cycles and never
        // wraps, even for the all-ones length.
        if (len_cnt_q == '0) begin
          state_d   = c_st_gap;
          gap_cnt_d = c_gap_load;
        end else begin
          len_cnt_d = len_cnt_q - c_len_one;
        end
      end
      c_st_gap: begin
        if (gap_cnt_q == '0) begin
          state_d = c_st_idle;
        end else begin
          gap_cnt_d = gap_cnt_q - c_gap_one;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // Output logic: computed from the next state so every output is a flop and
  // in_ready depends on state only, never combinationally on in_valid.
  always_comb begin
    o_d        = 8'h00;
    busy_d     = (state_d != c_st_idle);
    done_d     = (state_q == c_st_active) && (state_d == c_st_gap);
    in_ready_d = (state_d == c_st_idle);
    if (state_d == c_st_active) begin
      o_d = 8'h01 << idx_d;
    end
  end

  assign O        = o_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign in_ready = in_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_onehot_3to8_strobe_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_3to8_strobe_decoder
// Purpose  : Bench for onehot_3to8_strobe_decoder. Two instances (GAP_CYCLES
//            1 and 15) are driven independently; a timeline model predicts
//            every output in every cycle from the last accepted command.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_3to8_strobe_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid [2];
  logic [2:0] in_idx   [2];
  logic [3:0] in_len   [2];
  logic [7:0] o_w      [2];
  logic       ready_w  [2];
  logic       busy_w   [2];
  logic       done_w   [2];

  int         n_cmp;
  int         n_err;
  longint     cyc;

  // Model: last accepted command per instance, as an absolute cycle number.
  bit         has_cmd [2];
  longint     acc_cyc [2];
  int         m_len   [2];
  int         m_idx   [2];

  onehot_3to8_strobe_decoder #(.GAP_CYCLES(1), .LEN_W(4)) u_dut_g1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid[0]),
    .in_ready (ready_w[0]),
    .in_idx   (in_idx[0]),
    .in_len   (in_len[0]),
    .O        (o_w[0]),
    .busy     (busy_w[0]),
    .done     (done_w[0])
  );

  onehot_3to8_strobe_decoder #(.GAP_CYCLES(15), .LEN_W(4)) u_dut_g15 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid[1]),
    .in_ready (ready_w[1]),
    .in_idx   (in_idx[1]),
    .in_len   (in_len[1]),
    .O        (o_w[1]),
    .busy     (busy_w[1]),
    .done     (done_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-cycle reference check, then decide whether the next edge accepts.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      longint c;
      int     gap;
      bit     e_act, e_done, e_busy, e_ready;
      logic [7:0] e_o;
      c   = cyc;
      gap = (d == 0) ? 1 : 15;
      if (!rst_n) has_cmd[d] = 1'b0;
      e_act   = has_cmd[d] && (c >= acc_cyc[d] + 1) && (c <= acc_cyc[d] + 1 + m_len[d]);
      e_done  = has_cmd[d] && (c == acc_cyc[d] + 2 + m_len[d]);
      e_busy  = has_cmd[d] && (c >= acc_cyc[d] + 1) && (c <= acc_cyc[d] + 1 + m_len[d] + gap);
      e_ready = !e_busy;
      e_o     = e_act ? 8'(1 << m_idx[d]) : 8'h00;
      check_eq($sformatf("O[%0d]", d), 32'(o_w[d]), 32'(e_o));
      check_eq($sformatf("busy[%0d]", d), 32'(busy_w[d]), 32'(e_busy));
      check_eq($sformatf("done[%0d]", d), 32'(done_w[d]), 32'(e_done));
      check_eq($sformatf("in_ready[%0d]", d), 32'(ready_w[d]), 32'(e_ready));
      check_eq($sformatf("onehot[%0d]", d), 32'($countones(o_w[d]) <= 1), 32'd1);
      if (rst_n && in_valid[d] && e_ready) begin
        has_cmd[d] = 1'b1;
        acc_cyc[d] = c;
        m_len[d]   = int'(in_len[d]);
        m_idx[d]   = int'(in_idx[d]);
      end
    end
  end

  // Present a command and leave in_valid high; returns just after the
  // accepting edge.
  task automatic send(input int d, input int idx, input int len);
    int n;
    in_valid[d] = 1'b1;
    in_idx[d]   = 3'(idx);
    in_len[d]   = 4'(len);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (ready_w[d]) break;
      if (n >= 200) begin
        check_eq("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_w[d] && n < 200);
    if (!ready_w[d]) check_eq("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      in_idx[d]   = 3'd0;
      in_len[d]   = 4'd0;
      has_cmd[d]  = 1'b0;
      acc_cyc[d]  = 0;
      m_len[d]    = 0;
      m_idx[d]    = 0;
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single short command.
    send(0, 5, 0);
    in_valid[0] = 1'b0;
    wait_idle(0);

    // Every index, three-cycle strobes.
    for (int i = 0; i < 8; i++) begin
      send(0, i, 2);
      in_valid[0] = 1'b0;
      wait_idle(0);
    end

    // Back-to-back with in_valid held high.
    send(0, 3, 1);
    send(0, 6, 0);
    in_valid[0] = 1'b0;
    wait_idle(0);

    // Inputs changing while busy must be ignored.
    send(0, 1, 4);
    in_valid[0] = 1'b0;
    in_idx[0]   = 3'd7;
    in_len[0]   = 4'd15;
    wait_idle(0);

    // Longest strobe and longest gap.
    send(1, 2, 15);
    in_valid[1] = 1'b0;
    in_idx[1]   = 3'd5;
    wait_idle(1);

    // Asynchronous reset in the third strobe cycle.
    send(0, 4, 7);
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check_eq("pre_rst_O", 32'(o_w[0]), 32'h10);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_O", 32'(o_w[0]), 32'h00);
    check_eq("async_rst_busy", 32'(busy_w[0]), 32'd0);
    check_eq("async_rst_done", 32'(done_w[0]), 32'd0);
    check_eq("async_rst_ready", 32'(ready_w[0]), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 0, 0);
    in_valid[0] = 1'b0;
    wait_idle(0);

    // Randomised traffic on both instances.
    repeat (3000) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        in_valid[d] = ($urandom_range(0, 3) != 0);
        in_idx[d]   = 3'($urandom_range(0, 7));
        r = $urandom_range(0, 5);
        in_len[d]   = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(0, 15));
      end
    end
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/onehot_3to8_strobe_decoder.md
# onehot_3to8_strobe_decoder

Sequenced 3-to-8 one-hot decoder. It accepts a binary index plus hold length over a valid/ready handshake, then drives exactly one of eight output lines for a programmed number of cycles. A mandatory all-zero gap follows each strobe, giving break-before-make between consecutive selections. It sits on the producing side of the one-hot select bus that the 8:3 one-hot encoder consumes, and regenerates legal one-hot codes from 3-bit indices.

## Interface
- GAP_CYCLES, 1, number of all-zero cycles after each strobe; legal range 1..15.
- LEN_W, 4, width of the hold-length field.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; release is synchronised externally.
- in_valid  input  1  command valid.
- in_ready  output  1  block can accept a command.
- in_idx  input  3  line to assert, 0..7.
- in_len  input  LEN_W  hold length minus one; the strobe lasts in_len+1 cycles.
- O  output  8  one-hot strobe; all zero when not strobing.
- busy  output  1  high in ACTIVE and GAP.
- done  output  1  one-cycle pulse marking the end of a strobe.

## Operation
- FSM states:
  - IDLE: in_ready=1, O=0, busy=0.
  - ACTIVE: O = 8'b1 << idx_q, busy=1.
  - GAP: O=0, busy=1.
- Transitions:
  - IDLE -> ACTIVE on the edge where in_valid && in_ready. On that edge, capture idx_q=in_idx, load len_cnt=in_len.
  - ACTIVE: if len_cnt==0, go to GAP and load gap_cnt=GAP_CYCLES-1. Otherwise decrement len_cnt.
  - GAP: if gap_cnt==0, go to IDLE. Otherwise decrement gap_cnt.
- Inputs are sampled only at the accepting edge. Changes to in_idx or in_len while busy have no effect.
- in_valid while not ready is held off, not dropped. The command is accepted when the block returns to IDLE, provided in_valid is still high.
- Outputs are registered. O has at most one bit set in every cycle; any other value is an error.
- in_len=0 gives a single-cycle strobe. in_len=2^LEN_W-1 gives the maximum strobe of 2^LEN_W cycles. Counters must not wrap.
- done=1 for exactly the first GAP cycle of each command.
- Reset values, applied asynchronously on rst_n low at any point including mid-strobe: state=IDLE, O=8'h00, busy=0, done=0, in_ready=1, idx_q=0, counters=0. No done pulse is generated for a command aborted by reset.

## Timing
- Accept edge at cycle T. O goes non-zero in cycle T+1 (latency 1) and stays valid for cycles T+1..T+1+in_len.
- GAP runs over cycles T+2+in_len .. T+1+in_len+GAP_CYCLES. done is high in cycle T+2+in_len.
- in_ready rises in cycle T+2+in_len+GAP_CYCLES.
- A back-to-back command, with in_valid held high, is accepted at that edge. Sustained throughput is therefore one command per in_len+GAP_CYCLES+2 cycles.
- in_ready is a function of state only. It has no combinational path from in_valid.

## Test plan
- Reset values, then a single command. Hold rst_n=0 and check O=00, in_ready=1, busy=0, done=0. Release reset, send idx=5, len=0 at cycle T. Expect O=8'h20 in T+1 only, O=00 with done=1 in T+2, and in_ready=1 again in T+3 (GAP_CYCLES=1).
- All indices. Send idx=0..7 in sequence, each with len=2. Expect O=01,02,04,…,80, each held 3 cycles, each followed by one zero cycle. Also expect O to never have more than one bit set.
- Back-to-back. Hold in_valid=1 and send idx=3, len=1 then idx=6, len=0. Expect 08,08,00,(idle),40,00. done must pulse twice, and the second command must not be accepted while busy.
- Input change while busy. Accept idx=1, len=4, then change in_idx to 7 during ACTIVE. Expect O=02 for 5 cycles; the value 80 must never appear.
- Maximum length and gap. With LEN_W=4 and GAP_CYCLES=15, send idx=2, len=15. Expect O=04 for 16 cycles, then 15 zero cycles, then in_ready=1, with no counter wrap.
- Reset mid-strobe. Assert rst_n=0 during cycle 3 of an idx=4, len=7 strobe. Expect O=00 and busy=0 immediately, without waiting for a clock edge, and no done pulse. After release, a new command idx=0 must give O=01 with normal latency.
